// File: rtl/udp_rx_parser.sv
// UDP receive parser: checks MAC/IPv4/UDP headers of an 8-bit AXIS frame and repacks
// the UDP payload into MSB-first 32-bit words for the application.
module udp_rx_parser #(
  parameter bit ACCEPT_BCAST = 1'b1,
  parameter bit DEBUG        = 1'b0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] local_IP_in,
  input  logic [47:0] local_MAC_in,
  input  logic [15:0] local_port_in,
  input  logic [7:0]  axis_tdata_in,
  input  logic        axis_tvalid_in,
  input  logic        axis_tlast_in,
  output logic        axis_tready_out,
  output logic [31:0] udp_to_app_data,
  output logic [3:0]  udp_to_app_keep,
  output logic        udp_to_app_valid,
  output logic        udp_to_app_last,
  output logic        udp_to_app_err,
  input  logic        udp_from_app_ready,
  output logic [31:0] src_ip_out,
  output logic [15:0] src_port_out,
  output logic [15:0] good_cnt,
  output logic [15:0] drop_cnt
);

  // state   | meaning
  // S_HDR   | counting header bytes 0..41, checking fields on the fly
  // S_PAYLOAD | packing UDP payload bytes into output words
  // S_TAIL  | discarding Ethernet pad after the datagram until tlast
  // S_DROP  | discarding a rejected frame until tlast
  typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_TAIL, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [5:0]  byte_cnt_q, byte_cnt_d;
  logic        bad_q, bad_d;
  logic        mac_bad_q, mac_bad_d;
  logic        bc_bad_q, bc_bad_d;
  logic [15:0] len_q, len_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] hdr_ip_q, hdr_ip_d;
  logic [15:0] hdr_port_q, hdr_port_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [15:0] src_port_q, src_port_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  acc_n_q, acc_n_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  keep_q, keep_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [15:0] good_q, good_d;
  logic [15:0] drop_q, drop_d;

  logic        accept;
  logic        hdr_bad;
  logic        chk_en, mac_en;
  logic [7:0]  exp_byte, mac_byte;
  logic [31:0] word_ins;

  if (DEBUG) begin : g_debug
  end

  function automatic logic [3:0] keep_of(input logic [1:0] n);
    case (n)
      2'd0:    keep_of = 4'b1000;
      2'd1:    keep_of = 4'b1100;
      2'd2:    keep_of = 4'b1110;
      default: keep_of = 4'b1111;
    endcase
  endfunction

  assign axis_tready_out = (state_q == S_DROP || state_q == S_TAIL) ? 1'b1
                         : (!valid_q || udp_from_app_ready);
  assign accept  = axis_tvalid_in && axis_tready_out;
  assign hdr_bad = bad_q || (mac_bad_q && (bc_bad_q || !ACCEPT_BCAST));

  always_comb begin
    chk_en   = 1'b1;
    exp_byte = 8'h00;
    case (byte_cnt_q)
      6'd12:   exp_byte = 8'h08;
      6'd13:   exp_byte = 8'h00;
      6'd14:   exp_byte = 8'h45;
      6'd23:   exp_byte = 8'h11;
      6'd30:   exp_byte = local_IP_in[31:24];
      6'd31:   exp_byte = local_IP_in[23:16];
      6'd32:   exp_byte = local_IP_in[15:8];
      6'd33:   exp_byte = local_IP_in[7:0];
      6'd36:   exp_byte = local_port_in[15:8];
      6'd37:   exp_byte = local_port_in[7:0];
      default: chk_en = 1'b0;
    endcase
  end

  always_comb begin
    mac_en   = 1'b1;
    mac_byte = 8'h00;
    case (byte_cnt_q)
      6'd0:    mac_byte = local_MAC_in[47:40];
      6'd1:    mac_byte = local_MAC_in[39:32];
      6'd2:    mac_byte = local_MAC_in[31:24];
      6'd3:    mac_byte = local_MAC_in[23:16];
      6'd4:    mac_byte = local_MAC_in[15:8];
      6'd5:    mac_byte = local_MAC_in[7:0];
      default: mac_en = 1'b0;
    endcase
  end

  always_comb begin
    word_ins = acc_q;
    case (acc_n_q)
      2'd0:    word_ins[31:24] = axis_tdata_in;
      2'd1:    word_ins[23:16] = axis_tdata_in;
      2'd2:    word_ins[15:8]  = axis_tdata_in;
      default: word_ins[7:0]   = axis_tdata_in;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bad_d      = bad_q;
    mac_bad_d  = mac_bad_q;
    bc_bad_d   = bc_bad_q;
    len_d      = len_q;
    rem_d      = rem_q;
    hdr_ip_d   = hdr_ip_q;
    hdr_port_d = hdr_port_q;
    src_ip_d   = src_ip_q;
    src_port_d = src_port_q;
    acc_d      = acc_q;
    acc_n_d    = acc_n_q;
    data_d     = data_q;
    keep_d     = keep_q;
    valid_d    = valid_q;
    last_d     = last_q;
    err_d      = err_q;
    good_d     = good_q;
    drop_d     = drop_q;

    if (valid_q && udp_from_app_ready) valid_d = 1'b0;

    case (state_q)
      S_HDR: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 6'd1;
          if (mac_en && axis_tdata_in != mac_byte) mac_bad_d = 1'b1;
          if (mac_en && axis_tdata_in != 8'hFF)    bc_bad_d  = 1'b1;
          if (chk_en && axis_tdata_in != exp_byte) bad_d     = 1'b1;
          case (byte_cnt_q)
            6'd26: hdr_ip_d[31:24]  = axis_tdata_in;
            6'd27: hdr_ip_d[23:16]  = axis_tdata_in;
            6'd28: hdr_ip_d[15:8]   = axis_tdata_in;
            6'd29: hdr_ip_d[7:0]    = axis_tdata_in;
            6'd34: hdr_port_d[15:8] = axis_tdata_in;
            6'd35: hdr_port_d[7:0]  = axis_tdata_in;
            6'd38: len_d[15:8]      = axis_tdata_in;
            6'd39: begin
              len_d[7:0] = axis_tdata_in;
              if ({len_q[15:8], axis_tdata_in} < 16'd8) bad_d = 1'b1;
            end
            default: ;
          endcase
          if (byte_cnt_q == 6'd41) begin
            byte_cnt_d = 6'd0;
            bad_d      = 1'b0;
            mac_bad_d  = 1'b0;
            bc_bad_d   = 1'b0;
            if (hdr_bad) begin
              drop_d  = drop_q + 16'd1;
              state_d = axis_tlast_in ? S_HDR : S_DROP;
            end else begin
              src_ip_d   = hdr_ip_q;
              src_port_d = hdr_port_q;
              if (len_q == 16'd8) begin
                good_d  = good_q + 16'd1;
                state_d = axis_tlast_in ? S_HDR : S_TAIL;
              end else if (axis_tlast_in) begin
                // header complete but no payload arrived: empty truncated word
                data_d  = 32'h0;
                keep_d  = 4'b0000;
                valid_d = 1'b1;
                last_d  = 1'b1;
                err_d   = 1'b1;
                drop_d  = drop_q + 16'd1;
                state_d = S_HDR;
              end else begin
                rem_d   = len_q - 16'd8;
                acc_d   = 32'h0;
                acc_n_d = 2'd0;
                state_d = S_PAYLOAD;
              end
            end
          end else if (axis_tlast_in) begin
            byte_cnt_d = 6'd0;
            bad_d      = 1'b0;
            mac_bad_d  = 1'b0;
            bc_bad_d   = 1'b0;
            drop_d     = drop_q + 16'd1;
          end
        end
      end

      S_PAYLOAD: begin
        if (accept) begin
          rem_d = rem_q - 16'd1;
          if (acc_n_q == 2'd3 || rem_q == 16'd1 || axis_tlast_in) begin
            data_d  = word_ins;
            keep_d  = keep_of(acc_n_q);
            valid_d = 1'b1;
            last_d  = (rem_q == 16'd1) || axis_tlast_in;
            err_d   = (rem_q != 16'd1) && axis_tlast_in;
            acc_d   = 32'h0;
            acc_n_d = 2'd0;
          end else begin
            acc_d   = word_ins;
            acc_n_d = acc_n_q + 2'd1;
          end
          if (rem_q == 16'd1) begin
            good_d  = good_q + 16'd1;
            state_d = axis_tlast_in ? S_HDR : S_TAIL;
          end else if (axis_tlast_in) begin
            drop_d  = drop_q + 16'd1;
            state_d = S_HDR;
          end
        end
      end

      S_TAIL, S_DROP: begin
        if (accept && axis_tlast_in) state_d = S_HDR;
      end

      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_HDR;
      byte_cnt_q <= 6'd0;
      bad_q      <= 1'b0;
      mac_bad_q  <= 1'b0;
      bc_bad_q   <= 1'b0;
      len_q      <= 16'h0;
      rem_q      <= 16'h0;
      hdr_ip_q   <= 32'h0;
      hdr_port_q <= 16'h0;
      src_ip_q   <= 32'h0;
      src_port_q <= 16'h0;
      acc_q      <= 32'h0;
      acc_n_q    <= 2'd0;
      data_q     <= 32'h0;
      keep_q     <= 4'h0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      good_q     <= 16'h0;
      drop_q     <= 16'h0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bad_q      <= bad_d;
      mac_bad_q  <= mac_bad_d;
      bc_bad_q   <= bc_bad_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      hdr_ip_q   <= hdr_ip_d;
      hdr_port_q <= hdr_port_d;
      src_ip_q   <= src_ip_d;
      src_port_q <= src_port_d;
      acc_q      <= acc_d;
      acc_n_q    <= acc_n_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      err_q      <= err_d;
      good_q     <= good_d;
      drop_q     <= drop_d;
    end
  end

  assign udp_to_app_data  = data_q;
  assign udp_to_app_keep  = keep_q;
  assign udp_to_app_valid = valid_q;
  assign udp_to_app_last  = last_q;
  assign udp_to_app_err   = err_q;
  assign src_ip_out       = src_ip_q;
  assign src_port_out     = src_port_q;
  assign good_cnt         = good_q;
  assign drop_cnt         = drop_q;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Directed bench for udp_rx_parser: builds frames byte by byte and compares the app-side
// words and counters against a small reference model of the packing rules.
module tb_udp_rx_parser;

  localparam logic [47:0] LMAC  = 48'h02_11_22_33_44_55;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] LIP   = 32'hC0A8_0A02;
  localparam logic [15:0] LPORT = 16'd5000;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  tdata = 8'h0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        tready, tready_nb;
  logic        app_ready = 1'b1;
  logic [31:0] data, data_nb;
  logic [3:0]  keep, keep_nb;
  logic        valid, valid_nb, last, last_nb, err, err_nb;
  logic [31:0] sip, sip_nb;
  logic [15:0] sport, sport_nb, good, good_nb, drop, drop_nb;
  logic        tvalid_nb;

  always #5 aclk = ~aclk;

  assign tvalid_nb = tvalid && tready;

  udp_rx_parser #(.ACCEPT_BCAST(1'b1), .DEBUG(1'b0)) dut (
    .aclk(aclk), .aresetn(aresetn), .local_IP_in(LIP), .local_MAC_in(LMAC),
    .local_port_in(LPORT), .axis_tdata_in(tdata), .axis_tvalid_in(tvalid),
    .axis_tlast_in(tlast), .axis_tready_out(tready), .udp_to_app_data(data),
    .udp_to_app_keep(keep), .udp_to_app_valid(valid), .udp_to_app_last(last),
    .udp_to_app_err(err), .udp_from_app_ready(app_ready), .src_ip_out(sip),
    .src_port_out(sport), .good_cnt(good), .drop_cnt(drop)
  );

  udp_rx_parser #(.ACCEPT_BCAST(1'b0), .DEBUG(1'b0)) dut_nb (
    .aclk(aclk), .aresetn(aresetn), .local_IP_in(LIP), .local_MAC_in(LMAC),
    .local_port_in(LPORT), .axis_tdata_in(tdata), .axis_tvalid_in(tvalid_nb),
    .axis_tlast_in(tlast), .axis_tready_out(tready_nb), .udp_to_app_data(data_nb),
    .udp_to_app_keep(keep_nb), .udp_to_app_valid(valid_nb), .udp_to_app_last(last_nb),
    .udp_to_app_err(err_nb), .udp_from_app_ready(1'b1), .src_ip_out(sip_nb),
    .src_port_out(sport_nb), .good_cnt(good_nb), .drop_cnt(drop_nb)
  );

  int total = 0;
  int bad = 0;
  bit rnd_rdy = 1'b0;
  logic [7:0]  fr[$];
  logic [7:0]  pay[$];
  logic [37:0] exp_q[$];
  logic [37:0] rx_q[$];
  logic [15:0] exp_good = 16'h0, exp_drop = 16'h0, exp_good_nb = 16'h0, exp_drop_nb = 16'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge aclk);
    #1;
    app_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // word record: {data, keep, last, err}
  always @(negedge aclk)
    if (aresetn && valid && app_ready) rx_q.push_back({data, keep, last, err});

  task automatic build_frame(input logic [47:0] dmac, input logic [15:0] etype,
                             input logic [7:0] proto, input logic [15:0] dport,
                             input logic [15:0] ulen, input int npay, input int npad,
                             input logic [31:0] s_ip, input logic [15:0] s_port,
                             input bit exp_words);
    logic [15:0] tot;
    int ndel;
    bit trunc;
    tot = ulen + 16'd20;
    fr.delete(); pay.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) fr.push_back(dmac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(8'(8'hA0 + i));
    fr.push_back(etype[15:8]); fr.push_back(etype[7:0]);
    fr.push_back(8'h45); fr.push_back(8'h00);
    fr.push_back(tot[15:8]); fr.push_back(tot[7:0]);
    for (int i = 0; i < 4; i++) fr.push_back(8'h00);
    fr.push_back(8'h40); fr.push_back(proto);
    fr.push_back(8'h00); fr.push_back(8'h00);
    for (int i = 0; i < 4; i++) fr.push_back(s_ip[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) fr.push_back(LIP[31-8*i -: 8]);
    fr.push_back(s_port[15:8]); fr.push_back(s_port[7:0]);
    fr.push_back(dport[15:8]); fr.push_back(dport[7:0]);
    fr.push_back(ulen[15:8]); fr.push_back(ulen[7:0]);
    fr.push_back(8'h00); fr.push_back(8'h00);
    for (int i = 0; i < npay; i++) pay.push_back(8'(i * 13 + int'(s_ip[7:0]) * 7 + 8'h5A));
    foreach (pay[i]) fr.push_back(pay[i]);
    for (int i = 0; i < npad; i++) fr.push_back(8'h00);
    if (exp_words) begin
      trunc = npay < int'(ulen) - 8;
      ndel  = trunc ? npay : int'(ulen) - 8;
      if (ndel == 0 && trunc) exp_q.push_back({32'h0, 4'b0000, 1'b1, 1'b1});
      for (int k = 0; k < ndel; k += 4) begin
        logic [31:0] w;
        logic [3:0]  kp;
        bit          fin;
        w = 32'h0; kp = 4'h0;
        for (int j = 0; j < 4; j++)
          if (k + j < ndel) begin
            w[31-8*j -: 8] = pay[k+j];
            kp[3-j] = 1'b1;
          end
        fin = (k + 4 >= ndel);
        exp_q.push_back({w, kp, fin, fin && trunc});
      end
    end
  endtask

  task automatic send_bytes(input int from, input int to, input bit last_at_end);
    for (int i = from; i <= to; i++) begin
      int n;
      tdata  = fr[i];
      tvalid = 1'b1;
      tlast  = last_at_end && (i == to);
      n = 0;
      forever begin
        @(negedge aclk);
        if (tready) break;
        n++;
        if (n > 200) begin
          check("tready_stall", tready, 1'b1);
          tvalid = 1'b0; tlast = 1'b0;
          return;
        end
      end
      @(posedge aclk);
      #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input int dg, input int dd,
                              input int dg_nb, input int dd_nb, input bit chk_src,
                              input logic [31:0] s_ip, input logic [15:0] s_port);
    rnd_rdy = 1'b0;
    repeat (30) @(posedge aclk);
    #1;
    exp_good    = exp_good + 16'(dg);
    exp_drop    = exp_drop + 16'(dd);
    exp_good_nb = exp_good_nb + 16'(dg_nb);
    exp_drop_nb = exp_drop_nb + 16'(dd_nb);
    check($sformatf("%s nwords", tag), rx_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < rx_q.size()) check($sformatf("%s word%0d", tag, i), rx_q[i], exp_q[i]);
    check($sformatf("%s good", tag), good, exp_good);
    check($sformatf("%s drop", tag), drop, exp_drop);
    check($sformatf("%s good_nb", tag), good_nb, exp_good_nb);
    check($sformatf("%s drop_nb", tag), drop_nb, exp_drop_nb);
    if (chk_src) begin
      check($sformatf("%s src_ip", tag), sip, s_ip);
      check($sformatf("%s src_port", tag), sport, s_port);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    check("rst valid", valid, 1'b0);
    check("rst good", good, 16'h0);
    check("rst drop", drop, 16'h0);
    check("rst data", data, 32'h0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("rst tready", tready, 1'b1);

    build_frame(LMAC, 16'h0800, 8'h11, LPORT, 16'd72, 64, 0, 32'h0A000001, 16'd1001, 1'b1);
    send_bytes(0, fr.size() - 1, 1'b1);
    finish_frame("L72", 1, 0, 1, 0, 1'b1, 32'h0A000001, 16'd1001);

    build_frame(LMAC, 16'h0800, 8'h11, LPORT, 16'd13, 5, 13, 32'h0A000002, 16'd1002, 1'b1);
    send_bytes(0, fr.size() - 1, 1'b1);
    finish_frame("L13pad", 1, 0, 1, 0, 1'b1, 32'h0A000002, 16'd1002);

    build_frame(LMAC, 16'h0800, 8'h11, 16'd5001, 16'd16, 8, 0, 32'h0A000003, 16'd1003, 1'b0);
    send_bytes(0, fr.size() - 1, 1'b1);
    finish_frame("badport", 0, 1, 0, 1, 1'b1, 32'h0A000002, 16'd1002);

    build_frame(LMAC, 16'h0800, 8'h06, LPORT, 16'd16, 8, 0, 32'h0A000004, 16'd1004, 1'b0);
    send_bytes(0, fr.size() - 1, 1'b1);
    finish_frame("tcp", 0, 1, 0, 1, 1'b0, 32'h0, 16'h0);

    build_frame(LMAC, 16'h0806, 8'h11, LPORT, 16'd16, 8, 0, 32'h0A000005, 16'd1005, 1'b0);
    send_bytes(0, fr.size() - 1, 1'b1);
    finish_frame("arp", 0, 1, 0, 1, 1'b0, 32'h0, 16'h0);

    build_frame(BCAST, 16'h0800, 8'h11, LPORT, 16'd16, 8, 0, 32'h0A000006, 16'd1006, 1'b1);
    send_bytes(0, fr.size() - 1, 1'b1);
    finish_frame("bcast", 1, 0, 0, 1, 1'b1, 32'h0A000006, 16'd1006);

    build_frame(LMAC, 16'h0800, 8'h11, LPORT, 16'd24, 6, 0, 32'h0A000007, 16'd1007, 1'b1);
    send_bytes(0, fr.size() - 1, 1'b1);
    finish_frame("trunc", 0, 1, 0, 1, 1'b1, 32'h0A000007, 16'd1007);

    build_frame(LMAC, 16'h0800, 8'h11, LPORT, 16'd8, 0, 18, 32'h0A000008, 16'd1008, 1'b1);
    send_bytes(0, fr.size() - 1, 1'b1);
    finish_frame("L8", 1, 0, 1, 0, 1'b1, 32'h0A000008, 16'd1008);

    build_frame(LMAC, 16'h0800, 8'h11, LPORT, 16'd16, 8, 0, 32'h0A000009, 16'd1009, 1'b0);
    send_bytes(0, 19, 1'b1);
    finish_frame("runt", 0, 1, 0, 1, 1'b0, 32'h0, 16'h0);

    build_frame(LMAC, 16'h0800, 8'h11, LPORT, 16'd45, 37, 3, 32'h0A00000A, 16'd1010, 1'b1);
    rnd_rdy = 1'b1;
    send_bytes(0, fr.size() - 1, 1'b1);
    finish_frame("bp_rand", 1, 0, 1, 0, 1'b1, 32'h0A00000A, 16'd1010);

    build_frame(LMAC, 16'h0800, 8'h11, LPORT, 16'd11, 3, 0, 32'h0A00000B, 16'd1011, 1'b1);
    send_bytes(0, fr.size() - 1, 1'b1);
    finish_frame("L11", 1, 0, 1, 0, 1'b1, 32'h0A00000B, 16'd1011);

    build_frame(LMAC, 16'h0800, 8'h11, LPORT, 16'd5, 0, 10, 32'h0A00000C, 16'd1012, 1'b0);
    send_bytes(0, fr.size() - 1, 1'b1);
    finish_frame("Llt8", 0, 1, 0, 1, 1'b1, 32'h0A00000B, 16'd1011);

    build_frame(LMAC, 16'h0800, 8'h11, LPORT, 16'd48, 40, 0, 32'h0A00000D, 16'd1013, 1'b0);
    send_bytes(0, 19, 1'b0);
    aresetn = 1'b0;
    #20;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    exp_good = 16'h0; exp_drop = 16'h0; exp_good_nb = 16'h0; exp_drop_nb = 16'h0;
    rx_q.delete();
    send_bytes(20, fr.size() - 1, 1'b1);
    finish_frame("midrst", 0, 1, 0, 1, 1'b1, 32'h0, 16'h0);

    build_frame(LMAC, 16'h0800, 8'h11, LPORT, 16'd20, 12, 6, 32'h0A00000E, 16'd1014, 1'b1);
    send_bytes(0, fr.size() - 1, 1'b1);
    finish_frame("after_rst", 1, 0, 1, 0, 1'b1, 32'h0A00000E, 16'd1014);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
